// File: rtl/imem_fetch_seq.sv
// imem_fetch_seq
//   Fetch sequencer between the PC logic and a byte-wide instruction memory.
//   Reads one byte per cycle and packs four bytes big-endian (lowest address
//   lands in [31:24]). The finished word is offered to IF/ID with a
//   valid/ready handshake. Redirects load a new PC from any state. A
//   misaligned or out-of-range PC parks the block in FAULT.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   redirect_valid load redirect_pc as the new fetch PC
//   redirect_pc    redirect target
//   mem_addr       byte address to the instruction memory (combinational)
//   mem_rdata      byte read back in the same cycle
//   ins_valid      ins_data/ins_pc hold a complete instruction
//   ins_ready      IF/ID accepts the instruction (0 = stall)
//   ins_data       assembled instruction
//   ins_pc         address of ins_data
//   fault          sticky misaligned/out-of-range indication
//   fetch_cnt      count of accepted handshakes, wraps
module imem_fetch_seq #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 512,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      mem_addr,
  input  logic [7:0]       mem_rdata,
  output logic             ins_valid,
  input  logic             ins_ready,
  output logic [31:0]      ins_data,
  output logic [31:0]      ins_pc,
  output logic             fault,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, FAULT = 2'd2} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg;
  logic [1:0]  idx_reg;
  logic [31:0] pc_plus4;
  logic        handshake;

  // A fetch is legal when the PC is word aligned and all four bytes lie
  // inside memory. The sum is formed in 33 bits so that a PC near 2^32
  // cannot wrap around into range.
  function automatic logic pc_legal(input logic [31:0] addr);
    logic [32:0] last_byte;
    last_byte = {1'b0, addr} + 33'd3;
    return (addr[1:0] == 2'b00) && (last_byte < 33'(MEM_BYTES));
  endfunction

  assign pc_plus4  = pc_reg + 32'd4;
  assign handshake = (state_reg == HOLD) && ins_valid && ins_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= FETCH;
    else        state_reg <= state_next;
  end

  // Next-state logic; a redirect overrides whatever the FSM would do
  always_comb begin
    state_next = state_reg;
    if (redirect_valid) begin
      state_next = pc_legal(redirect_pc) ? FETCH : FAULT;
    end else begin
      case (state_reg)
        FETCH: begin
          // Catches an illegal RESET_PC on the first edge after release
          if (!pc_legal(pc_reg))   state_next = FAULT;
          else if (idx_reg == 2'd3) state_next = HOLD;
        end
        HOLD: begin
          if (ins_ready) state_next = pc_legal(pc_plus4) ? FETCH : FAULT;
        end
        FAULT:   state_next = FAULT;
        default: state_next = FETCH;
      endcase
    end
  end

  // Output logic
  always_comb begin
    mem_addr = pc_reg;
    if (state_reg == FETCH) mem_addr = pc_reg + {30'd0, idx_reg};
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg    <= RESET_PC;
      idx_reg   <= 2'd0;
      ins_valid <= 1'b0;
      ins_data  <= 32'd0;
      ins_pc    <= 32'd0;
      fault     <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      // A handshake still counts when it coincides with a redirect
      if (handshake) fetch_cnt <= fetch_cnt + CNT_W'(1);

      if (redirect_valid) begin
        pc_reg    <= redirect_pc;
        idx_reg   <= 2'd0;
        ins_valid <= 1'b0;
        fault     <= !pc_legal(redirect_pc);
      end else begin
        case (state_reg)
          FETCH: begin
            if (!pc_legal(pc_reg)) begin
              fault   <= 1'b1;
              idx_reg <= 2'd0;
            end else begin
              ins_data <= {ins_data[23:0], mem_rdata};
              idx_reg  <= idx_reg + 2'd1;  // wraps to 0 after the last byte
              if (idx_reg == 2'd3) begin
                ins_pc    <= pc_reg;
                ins_valid <= 1'b1;
              end
            end
          end
          HOLD: begin
            if (ins_ready) begin
              pc_reg    <= pc_plus4;
              ins_valid <= 1'b0;
              if (!pc_legal(pc_plus4)) fault <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_seq.sv
module tb_imem_fetch_seq;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [31:0]      mem_addr;
  logic [7:0]       mem_rdata;
  logic             ins_valid;
  logic             ins_ready;
  logic [31:0]      ins_data;
  logic [31:0]      ins_pc;
  logic             fault;
  logic [CNT_W-1:0] fetch_cnt;

  logic [7:0] mem [0:511];

  int errors = 0;
  int checks = 0;

  imem_fetch_seq #(.RESET_PC(32'h0), .MEM_BYTES(512), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_data(ins_data), .ins_pc(ins_pc),
    .fault(fault), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  // Combinational byte memory; addresses beyond the array read as zero
  assign mem_rdata = (mem_addr < 32'd512) ? mem[mem_addr[8:0]] : 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    {mem[0], mem[1], mem[2], mem[3]}             = 32'h20080005;
    {mem[4], mem[5], mem[6], mem[7]}             = 32'h8C090004;
    {mem[16], mem[17], mem[18], mem[19]}         = 32'hDEADBEEF;
    {mem[64], mem[65], mem[66], mem[67]}         = 32'h11223344;
    {mem[508], mem[509], mem[510], mem[511]}     = 32'hAABBCCDD;

    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; ins_ready = 1'b1;
    #1;
    chk("rst_valid", {31'd0, ins_valid}, 32'd0);
    chk("rst_data",  ins_data, 32'd0);
    chk("rst_pc",    ins_pc, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_cnt",   {16'd0, fetch_cnt}, 32'd0);
    chk("rst_addr",  mem_addr, 32'd0);

    @(posedge clk); #1 rst_n = 1'b1;

    // First word: valid exactly on the 4th edge after release
    repeat (3) step();
    chk("w0_early_v", {31'd0, ins_valid}, 32'd0);
    chk("w0_addr3",   mem_addr, 32'd3);
    step();
    chk("w0_valid", {31'd0, ins_valid}, 32'd1);
    chk("w0_data",  ins_data, 32'h20080005);
    chk("w0_pc",    ins_pc, 32'd0);
    chk("w0_cnt",   {16'd0, fetch_cnt}, 32'd0);

    // Second word: 5 cycles later with ready held high
    repeat (4) step();
    chk("w1_early_v", {31'd0, ins_valid}, 32'd0);
    chk("w1_cnt1",    {16'd0, fetch_cnt}, 32'd1);
    step();
    chk("w1_valid", {31'd0, ins_valid}, 32'd1);
    chk("w1_data",  ins_data, 32'h8C090004);
    chk("w1_pc",    ins_pc, 32'd4);

    // Stall for 10 cycles in HOLD
    ins_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_valid", {31'd0, ins_valid}, 32'd1);
      chk("stall_data",  ins_data, 32'h8C090004);
      chk("stall_pc",    ins_pc, 32'd4);
      chk("stall_addr",  mem_addr, 32'd4);
      chk("stall_cnt",   {16'd0, fetch_cnt}, 32'd1);
    end
    ins_ready = 1'b1;
    step();
    chk("release_cnt",   {16'd0, fetch_cnt}, 32'd2);
    chk("release_valid", {31'd0, ins_valid}, 32'd0);
    chk("release_addr",  mem_addr, 32'd8);

    // Redirect to 0x40 while fetching byte idx 2 of the word at 0x8
    repeat (2) step();
    chk("pre_rd_addr", mem_addr, 32'd10);
    ins_ready = 1'b0;
    redirect(32'h40);
    chk("rd40_valid", {31'd0, ins_valid}, 32'd0);
    chk("rd40_addr",  mem_addr, 32'h40);
    repeat (3) step();
    chk("rd40_early", {31'd0, ins_valid}, 32'd0);
    step();
    chk("rd40_v",    {31'd0, ins_valid}, 32'd1);
    chk("rd40_pc",   ins_pc, 32'h40);
    chk("rd40_data", ins_data, 32'h11223344);
    chk("rd40_cnt",  {16'd0, fetch_cnt}, 32'd2);

    // Misaligned redirect, then recovery
    redirect(32'h42);
    chk("rd42_fault", {31'd0, fault}, 32'd1);
    chk("rd42_valid", {31'd0, ins_valid}, 32'd0);
    chk("rd42_addr",  mem_addr, 32'h42);
    repeat (3) step();
    chk("rd42_stay",  {31'd0, fault}, 32'd1);
    chk("rd42_stayv", {31'd0, ins_valid}, 32'd0);
    redirect(32'h10);
    chk("rd10_fault", {31'd0, fault}, 32'd0);
    chk("rd10_addr",  mem_addr, 32'h10);
    repeat (4) step();
    chk("rd10_v",    {31'd0, ins_valid}, 32'd1);
    chk("rd10_pc",   ins_pc, 32'h10);
    chk("rd10_data", ins_data, 32'hDEADBEEF);

    // Redirect together with a HOLD handshake: count, but take the target
    ins_ready = 1'b1;
    redirect(32'h20);
    ins_ready = 1'b0;
    chk("rdhs_cnt",   {16'd0, fetch_cnt}, 32'd3);
    chk("rdhs_addr",  mem_addr, 32'h20);
    chk("rdhs_valid", {31'd0, ins_valid}, 32'd0);

    // Last legal word, then pc+4 runs off the end of memory
    redirect(32'h1FC);
    chk("rd1fc_fault", {31'd0, fault}, 32'd0);
    repeat (4) step();
    chk("w1fc_v",    {31'd0, ins_valid}, 32'd1);
    chk("w1fc_pc",   ins_pc, 32'h1FC);
    chk("w1fc_data", ins_data, 32'hAABBCCDD);
    ins_ready = 1'b1;
    step();
    ins_ready = 1'b0;
    chk("end_fault", {31'd0, fault}, 32'd1);
    chk("end_cnt",   {16'd0, fetch_cnt}, 32'd4);
    chk("end_addr",  mem_addr, 32'h200);
    chk("end_valid", {31'd0, ins_valid}, 32'd0);
    step();
    chk("end_stay", {31'd0, fault}, 32'd1);

    // Aligned PC whose +3 overflows 32 bits is out of range
    redirect(32'hFFFF_FFFC);
    chk("ovf_fault", {31'd0, fault}, 32'd1);
    chk("ovf_addr",  mem_addr, 32'hFFFF_FFFC);

    // Asynchronous reset in the middle of a word
    redirect(32'h0);
    chk("rd0_fault", {31'd0, fault}, 32'd0);
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_data",  ins_data, 32'd0);
    chk("arst_pc",    ins_pc, 32'd0);
    chk("arst_cnt",   {16'd0, fetch_cnt}, 32'd0);
    chk("arst_addr",  mem_addr, 32'd0);
    chk("arst_valid", {31'd0, ins_valid}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) step();
    chk("post_v",    {31'd0, ins_valid}, 32'd1);
    chk("post_data", ins_data, 32'h20080005);
    chk("post_pc",   ins_pc, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
